imem_loader: RTL and testbench

Boot-time instruction memory writer: the write-side counterpart of the fetch path. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into instruction memory starting at byte address 0. While a load is in progress it holds the fetch stage stalled, so the PC does not advance over partially written memory.

---
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// slave = loader side, master = stream source / memory side.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: length-prefixed big-endian byte stream -> word writes.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  imem_loader_if.slave  bus,
  output logic          load_active_o,
  output logic          done_o,
  output logic          error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_FINISH
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_POST = S_CHECK;
`else
  localparam state_t S_POST = S_FINISH;
`endif

  localparam logic [32:0]       CAPACITY = 33'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  state_t              state_q, state_d;
  logic                error_q;
  logic                we_q;
  logic [7:0]          len_hi_q;
  logic [15:0]         words_left_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         asm_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic        rdy;
  logic        accept;
  logic [15:0] n_len;
  logic        start_fire, len_hi_fire, len_lo_fire, data_fire, wr_fire, err_set;

  always_comb begin
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA: rdy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:                    rdy = 1'b1;
`endif
      default:                    rdy = 1'b0;
    endcase
  end

  assign accept = bus.rx_valid && rdy;
  assign n_len  = {len_hi_q, bus.rx_data};

  always_comb begin
    state_d     = state_q;
    start_fire  = 1'b0;
    len_hi_fire = 1'b0;
    len_lo_fire = 1'b0;
    data_fire   = 1'b0;
    wr_fire     = 1'b0;
    err_set     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          start_fire = 1'b1;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_hi_fire = 1'b1;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_fire = 1'b1;
          // Reject lengths that would wrap the word index over written memory.
          if ({17'd0, n_len} > CAPACITY) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end else if (n_len == 16'd0) begin
            state_d = S_POST;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          data_fire = 1'b1;
          if (byte_cnt_q == 2'd3) begin
            wr_fire = 1'b1;
            if (words_left_q == 16'd1) state_d = S_POST;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (bus.rx_data == csum_q) begin
            state_d = S_FINISH;
          end else begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      error_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= wr_fire;
      if (start_fire)   error_q <= 1'b0;
      else if (err_set) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi_q     <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      if (start_fire) begin
        words_left_q <= '0;
        word_idx_q   <= '0;
        byte_cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q       <= '0;
`endif
      end
      if (len_hi_fire) len_hi_q     <= bus.rx_data;
      if (len_lo_fire) words_left_q <= n_len;
      if (data_fire) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        asm_q      <= {asm_q[15:0], bus.rx_data};
`ifdef LOADER_CHECKSUM_EN
        csum_q     <= csum_q ^ bus.rx_data;
`endif
      end
      if (wr_fire) begin
        addr_q       <= 32'(word_idx_q) << 2;
        wdata_q      <= {asm_q, bus.rx_data};
        word_idx_q   <= word_idx_q + IDX_ONE;
        words_left_q <= words_left_q - 16'd1;
      end
    end
  end

  assign bus.rx_ready   = rdy;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign load_active_o  = (state_q != S_IDLE);
  assign done_o         = (state_q == S_FINISH);
  assign error_o        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven, popped on imem_we.
module tb_imem_loader;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic load_active, done, error;

  imem_loader_if bus();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .bus          (bus),
    .load_active_o(load_active),
    .done_o       (done),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (done === 1'b1) done_cnt++;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexp", 32'(bus.imem_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.imem_addr, e[63:32]);
        chk("wr_data", bus.imem_wdata, e[31:0]);
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_active", 32'(load_active), 32'd1);
    chk("start_ready", 32'(bus.rx_ready), 32'd1);
    chk("start_errclr", 32'(error), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    guard = 0;
    do begin
      ok = bus.rx_ready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 20);
    if (!ok) chk("rx_timeout", 32'd0, 32'd1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic load(input int n, input bit gaps, input bit bad_cs);
    logic [7:0]  cs;
    logic [31:0] w;
    int d0;
    cs = 8'h00;
    d0 = done_cnt;
    do_start();
    send_byte(8'(n >> 8), gaps);
    send_byte(8'(n), gaps);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      exp_q.push_back({32'(i * 4), w});
      for (int k = 3; k >= 0; k--) begin
        send_byte(w[8*k +: 8], gaps);
        cs = cs ^ w[8*k +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_cs ? ~cs : cs, gaps);
    chk("end_we", 32'(bus.imem_we), 32'd0);
`else
    chk("end_we", 32'(bus.imem_we), 32'(n > 0));
`endif
    chk("end_done", 32'(done), 32'(!bad_cs));
    chk("end_error", 32'(error), 32'(bad_cs));
    chk("end_active", 32'(load_active), 32'(!bad_cs));
    chk("end_ready", 32'(bus.rx_ready), 32'd0);
    @(posedge clk); #1;
    chk("idle_active", 32'(load_active), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("done_cnt", 32'(done_cnt - d0), 32'(!bad_cs));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_we"}, 32'(bus.imem_we), 32'd0);
    chk({tag, "_addr"}, bus.imem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    chk({tag, "_active"}, 32'(load_active), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic fill_words();
    for (int i = 0; i < 8; i++) words[i] = $urandom;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    // Single word, no gaps
    words[0] = 32'hDEADBEEF;
    load(1, 1'b0, 1'b0);

    // Back-pressure with random gaps and stray start pulses
    fill_words();
    load(3, 1'b1, 1'b0);
    fill_words();
    load(4, 1'b1, 1'b0);

    // Oversize length: capacity is 4 words
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_active", 32'(load_active), 32'd0);
    chk("ovf_ready", 32'(bus.rx_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("ovf_sticky", 32'(error), 32'd1);

    // Zero length (start also clears the earlier error)
    load(0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    fill_words();
    load(1, 1'b0, 1'b1);
`endif

    // Reset mid-session after two data bytes
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h56;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rx_valid = 1'b0;
    chk("midrst_sb", 32'(exp_q.size()), 32'd0);

    fill_words();
    load(2, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
